// File: rtl/ag_ps2_tx_pkg.sv
// Shared definitions for the Agat PS/2 host transmitter: state encodings,
// frame bit counts and default cycle counts.
package ag_ps2_tx_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_INHIBIT = 3'd1;
    localparam logic [2:0] ST_RTS     = 3'd2;
    localparam logic [2:0] ST_BITS    = 3'd3;
    localparam logic [2:0] ST_ACK     = 3'd4;
    localparam logic [2:0] ST_RELEASE = 3'd5;

    localparam logic [3:0] N_LAST_DATA = 4'd8;
    localparam logic [3:0] N_PARITY    = 4'd9;
    localparam logic [3:0] N_STOP      = 4'd10;
    localparam logic [3:0] N_ACK       = 4'd11;

    localparam int DEF_INHIBIT_CYCLES = 120;
    localparam int DEF_TIMEOUT_CYCLES = 15000;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ag_ps2_tx_edge.sv
// PS/2 clock registration and falling-edge pulse, shared with the receiver.
module ag_ps2_edge (
    input  logic clk,
    input  logic reset,
    input  logic line,
    output logic fall
);

    logic cur;
    logic prev;

    // Idle-high reset value keeps a fall from appearing straight out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur  <= 1'b1;
            prev <= 1'b1;
        end else begin
            cur  <= line;
            prev <= cur;
        end
    end

    assign fall = prev & ~cur;

endmodule

// File: rtl/ag_ps2_tx.sv
// Host-to-device PS/2 transmitter for the Agat keyboard port.
// Define AG_PS2_TX_ACK_CHECK_EN to turn a device NACK at the ACK clock into tx_err.
module ag_ps2_tx
    import ag_ps2_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] ps2_bus,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam logic [13:0] INHIBIT_LAST = 14'(INHIBIT_CYCLES - 1);
    localparam logic [13:0] INHIBIT_PRE  = 14'(INHIBIT_CYCLES - 2);
    localparam logic [13:0] TIMEOUT_LAST = 14'(TIMEOUT_CYCLES - 1);

    logic [2:0]  state;
    logic [7:0]  data_q;
    logic        parity_q;
    logic [3:0]  n;
    logic [13:0] cnt;
    logic        nack_q;
    logic        fall;
    logic [3:0]  n_next;
    logic [2:0]  bit_idx;

    ag_ps2_edge u_edge (
        .clk   (clk),
        .reset (reset),
        .line  (ps2_bus[0]),
        .fall  (fall)
    );

    assign n_next  = n + 4'd1;
    // Fall 8 wraps to index 7 in three bits, so no special case is needed.
    assign bit_idx = n_next[2:0] - 3'd1;

    // cnt times the inhibit period, then is reused as the frame timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            data_q      <= 8'h00;
            parity_q    <= 1'b0;
            n           <= 4'd0;
            cnt         <= 14'd0;
            nack_q      <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tx_start) begin
                        data_q      <= tx_data;
                        parity_q    <= odd_parity(tx_data);
                        n           <= 4'd0;
                        cnt         <= 14'd0;
                        nack_q      <= 1'b0;
                        ps2_clk_oe  <= 1'b1;
                        ps2_data_oe <= 1'b0;
                        tx_busy     <= 1'b1;
                        state       <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    cnt <= cnt + 14'd1;
                    if (cnt == INHIBIT_PRE) begin
                        ps2_data_oe <= 1'b1;
                    end
                    if (cnt == INHIBIT_LAST) begin
                        ps2_clk_oe <= 1'b0;
                        state      <= ST_RTS;
                    end
                end
                ST_RTS: begin
                    cnt         <= 14'd0;
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b1;
                    state       <= ST_BITS;
                end
                ST_BITS, ST_ACK, ST_RELEASE: begin
                    if (cnt == TIMEOUT_LAST) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        tx_busy     <= 1'b0;
                        tx_err      <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 14'd1;
                        if (state == ST_BITS) begin
                            if (fall) begin
                                n <= n_next;
                                if (n_next <= N_LAST_DATA) begin
                                    ps2_data_oe <= ~data_q[bit_idx];
                                end else if (n_next == N_PARITY) begin
                                    ps2_data_oe <= ~parity_q;
                                end else begin
                                    ps2_data_oe <= 1'b0;
                                    state       <= ST_ACK;
                                end
                            end
                        end else if (state == ST_ACK) begin
                            if (fall) begin
                                n <= N_ACK;
`ifdef AG_PS2_TX_ACK_CHECK_EN
                                nack_q <= ps2_bus[1];
`else
                                nack_q <= 1'b0;
`endif
                                state <= ST_RELEASE;
                            end
                        end else begin
                            if (ps2_bus == 2'b11) begin
                                tx_busy <= 1'b0;
                                tx_err  <= nack_q;
                                tx_done <= ~nack_q;
                                state   <= ST_IDLE;
                            end
                        end
                    end
                end
                default: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    tx_busy     <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ag_ps2_tx.sv
// Scoreboard bench for ag_ps2_tx: a PS/2 device model clocks frames out of the
// transmitter while a monitor checks done/err pulses against queued expectations.
module tb_ag_ps2_tx;

    logic       clk;
    logic       reset;
    logic [1:0] ps2_bus;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;

    logic       dev_clk_low;
    logic       dev_data_low;

    int checks;
    int errors;

    // 1 = done expected, 2 = err expected
    logic [1:0] exp_res[$];
    logic       exp_bits[$];

    localparam int MODE_ACK     = 0;
    localparam int MODE_NACK    = 1;
    localparam int MODE_TIMEOUT = 2;
    localparam int MODE_RESET   = 3;

    ag_ps2_tx dut (
        .clk         (clk),
        .reset       (reset),
        .ps2_bus     (ps2_bus),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_err      (tx_err)
    );

    // Open-drain wired-AND of host and device pull-downs.
    assign ps2_bus = {~(ps2_data_oe | dev_data_low), ~(ps2_clk_oe | dev_clk_low)};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference frame: 8 data bits LSB first, odd parity, stop bit high.
    function automatic logic lineBit(input logic [7:0] b, input int k);
        if (k <= 8) return b[k-1];
        if (k == 9) return ($countones(b) % 2 == 0);
        return 1'b1;
    endfunction

    // Monitor: every done/err pulse must match the next queued outcome.
    always @(negedge clk) begin
        if (tx_done || tx_err) begin
            if (exp_res.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pulse: got done=%0d err=%0d, expected none", tx_done, tx_err);
            end else begin
                checkOutput("result", int'({tx_err, tx_done}), int'(exp_res.pop_front()));
                checkOutput("busy_at_pulse", int'(tx_busy), 0);
            end
        end
    end

    task automatic waitIdle();
        int i;
        for (i = 0; i < 200 && tx_busy; i++) @(negedge clk);
        if (tx_busy) checkOutput("idle_wait_timeout", 1, 0);
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int mode, input bit extra_start);
        int  hi;
        int  rise;
        int  cyc;
        bit  aborted;
        waitIdle();
        if (mode != MODE_TIMEOUT) begin
            for (int k = 1; k <= 10; k++) exp_bits.push_back(lineBit(b, k));
        end
        if (mode == MODE_ACK) exp_res.push_back(2'd1);
`ifdef AG_PS2_TX_ACK_CHECK_EN
        if (mode == MODE_NACK) exp_res.push_back(2'd2);
`else
        if (mode == MODE_NACK) exp_res.push_back(2'd1);
`endif
        if (mode == MODE_TIMEOUT) exp_res.push_back(2'd2);

        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = 8'h00;
        checkOutput("accept_busy", int'(tx_busy), 1);
        checkOutput("accept_clk_oe", int'(ps2_clk_oe), 1);

        hi   = 0;
        rise = 0;
        for (int i = 0; i < 1000 && ps2_clk_oe; i++) begin
            hi++;
            if (ps2_data_oe && rise == 0) rise = hi;
            @(negedge clk);
        end
        checkOutput("inhibit_len", hi, 120);
        checkOutput("start_bit_cycle", rise, 120);
        checkOutput("rts_data_oe", int'(ps2_data_oe), 1);

        if (mode == MODE_TIMEOUT) begin
            cyc = 0;
            while (!tx_err && cyc < 16000) begin
                @(negedge clk);
                cyc++;
            end
            checkOutput("timeout_seen", int'(tx_err), 1);
            checkOutput("timeout_window", int'(cyc >= 14999 && cyc <= 15003), 1);
            checkOutput("timeout_clk_oe", int'(ps2_clk_oe), 0);
            checkOutput("timeout_data_oe", int'(ps2_data_oe), 0);
            return;
        end

        aborted = 1'b0;
        repeat (5) @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
            if (k == 11 && mode == MODE_ACK) dev_data_low = 1'b1;
            dev_clk_low = 1'b1;
            if (extra_start && k == 3) begin
                tx_data  = 8'h3C;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
                tx_data  = 8'h00;
                repeat (9) @(negedge clk);
            end else begin
                repeat (10) @(negedge clk);
            end
            if (k <= 10) begin
                if (exp_bits.size() == 0) begin
                    checkOutput("bits_queue_empty", 1, 0);
                end else begin
                    checkOutput($sformatf("line_bit%0d", k), int'(ps2_bus[1]), int'(exp_bits.pop_front()));
                end
            end
            if (mode == MODE_RESET && k == 5) begin
                reset = 1'b1;
                @(negedge clk);
                checkOutput("reset_clk_oe", int'(ps2_clk_oe), 0);
                checkOutput("reset_data_oe", int'(ps2_data_oe), 0);
                checkOutput("reset_busy", int'(tx_busy), 0);
                reset = 1'b0;
                dev_clk_low = 1'b0;
                exp_bits.delete();
                aborted = 1'b1;
                break;
            end
            dev_clk_low = 1'b0;
            repeat (10) @(negedge clk);
        end
        dev_data_low = 1'b0;
        if (!aborted) waitIdle();
        repeat (5) @(negedge clk);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        tx_start     = 1'b0;
        tx_data      = 8'h00;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_clk_oe", int'(ps2_clk_oe), 0);
        checkOutput("rst_data_oe", int'(ps2_data_oe), 0);
        checkOutput("rst_busy", int'(tx_busy), 0);
        checkOutput("rst_done", int'(tx_done), 0);
        checkOutput("rst_err", int'(tx_err), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] directed frames");
        applyStimulus(8'hED, MODE_ACK, 1'b0);
        applyStimulus(8'h01, MODE_ACK, 1'b0);
        applyStimulus(8'hFF, MODE_ACK, 1'b0);
        applyStimulus(8'hF3, MODE_NACK, 1'b0);
        applyStimulus(8'h5A, MODE_ACK, 1'b1);
        applyStimulus(8'h96, MODE_RESET, 1'b0);
        applyStimulus(8'hA5, MODE_TIMEOUT, 1'b0);

        $display("[TB] random frames");
        for (int r = 0; r < 8; r++) begin
            applyStimulus(8'($urandom), ($urandom_range(0, 3) == 0) ? MODE_NACK : MODE_ACK,
                          1'($urandom_range(0, 1)));
        end

        repeat (10) @(negedge clk);
        checkOutput("pending_results", exp_res.size(), 0);
        checkOutput("pending_bits", exp_bits.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
